charge_counter: RTL

- Measurement front end of the RC time-to-digital converter.
- Drives the RC charge enable and counts clk cycles until the synchronized comparator input trips.
- Captures the count as a 24-bit value and raises a done flag.
- The captured value is the load value consumed by the downstream discharge countdown stage.

---
 rtl/tdc_pkg.sv | 16 +
 rtl/sync_ff.sv | 23 ++
 rtl/charge_counter.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/tdc_pkg.sv
// Shared definitions for the RC time-to-digital converter: measurement state
// encoding, the common result width and the saturation pattern.
package tdc_pkg;

  localparam int TDC_WIDTH = 24;

  // Wide enough for any practical counter width; users slice the low bits.
  localparam logic [63:0] TDC_ALL_ONES = '1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CHARGE = 2'd1,
    DONE   = 2'd2
  } state_e;

endpackage

// File: rtl/sync_ff.sv
// Reset-to-zero multi-flop synchronizer for asynchronous TDC inputs.
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] stages;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stages <= '0;
    end else begin
      stages <= {stages[STAGES-2:0], d};
    end
  end

  assign q = stages[STAGES-1];

endmodule

// File: rtl/charge_counter.sv
// RC charge-time measurement: counts clk cycles in CHARGE until the comparator trips.
// Define CHARGE_COUNTER_FILTER_EN to require FILTER_LEN consecutive high samples per trip.
module charge_counter
  import tdc_pkg::*;
#(
  parameter int WIDTH       = TDC_WIDTH,
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             clear,
  input  logic             comp_in,
  output logic             charge_en,
  output logic             busy,
  output logic [WIDTH-1:0] counter,
  output logic             finished,
  output logic             overflow
);

  localparam logic [WIDTH-1:0] SAT = TDC_ALL_ONES[WIDTH-1:0];

  state_e           state;
  state_e           state_next;
  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] count_next;
  logic [WIDTH-1:0] counter_next;
  logic [WIDTH-1:0] capture;
  logic             comp_sync;
  logic             trip;
  logic             saturated;
  logic             charge_en_next;
  logic             busy_next;
  logic             finished_next;
  logic             overflow_next;

  sync_ff #(
    .STAGES(SYNC_STAGES)
  ) u_comp_sync (
    .clk  (clk),
    .reset(reset),
    .d    (comp_in),
    .q    (comp_sync)
  );

  assign saturated = (count == SAT);

`ifdef CHARGE_COUNTER_FILTER_EN
  localparam int               RUN_W    = $clog2(FILTER_LEN + 1);
  localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(FILTER_LEN - 1);
  localparam logic [WIDTH-1:0] BACKOFF  = WIDTH'(FILTER_LEN - 1);

  logic [RUN_W-1:0] run;

  // Length of the current unbroken run of high samples seen while charging.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      run <= '0;
    end else if (state != CHARGE || !comp_sync) begin
      run <= '0;
    end else if (!trip) begin
      run <= run + RUN_W'(1);
    end
  end

  assign trip    = comp_sync && (run == RUN_LAST);
  // Report the cycle of the first high sample of the qualifying run.
  assign capture = (count >= BACKOFF) ? (count - BACKOFF) : '0;
`else
  logic unused_filter_len;

  assign unused_filter_len = FILTER_LEN[0];
  assign trip              = comp_sync;
  assign capture           = count;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      count     <= '0;
      counter   <= '0;
      finished  <= 1'b0;
      overflow  <= 1'b0;
      charge_en <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_next;
      count     <= count_next;
      counter   <= counter_next;
      finished  <= finished_next;
      overflow  <= overflow_next;
      charge_en <= charge_en_next;
      busy      <= busy_next;
    end
  end

  // clear outranks both start and trip in every state.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start && !clear) begin
          state_next = CHARGE;
        end
      end
      CHARGE: begin
        if (clear) begin
          state_next = IDLE;
        end else if (trip || saturated) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (clear) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    count_next     = count;
    counter_next   = counter;
    finished_next  = finished;
    overflow_next  = overflow;
    charge_en_next = charge_en;
    busy_next      = busy;
    case (state)
      IDLE: begin
        if (start && !clear) begin
          count_next     = '0;
          charge_en_next = 1'b1;
          busy_next      = 1'b1;
          finished_next  = 1'b0;
          overflow_next  = 1'b0;
        end
      end
      CHARGE: begin
        if (clear) begin
          charge_en_next = 1'b0;
          busy_next      = 1'b0;
        end else if (trip) begin
          counter_next   = capture;
          finished_next  = 1'b1;
          charge_en_next = 1'b0;
          busy_next      = 1'b0;
        end else if (saturated) begin
          counter_next   = SAT;
          overflow_next  = 1'b1;
          finished_next  = 1'b1;
          charge_en_next = 1'b0;
          busy_next      = 1'b0;
        end else begin
          count_next = count + WIDTH'(1);
        end
      end
      DONE: begin
        charge_en_next = 1'b0;
        busy_next      = 1'b0;
        if (clear) begin
          finished_next = 1'b0;
          overflow_next = 1'b0;
        end
      end
      default: begin
        charge_en_next = 1'b0;
        busy_next      = 1'b0;
      end
    endcase
  end

endmodule
